// File: rtl/sim_ram_pipe.sv
`timescale 1ns/1ps
// Simulation data RAM with valid/ready handshake, per-byte writes and LATENCY-cycle in-order responses.
// Optional out-of-range flagging is enabled by defining RAM_RANGE_CHECK_EN.
module sim_ram_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_LOG2 = 16,
    parameter int LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [DATA_WIDTH/8-1:0] req_wen,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BL    = $clog2(BYTES);
    localparam int WORDS = 1 << DEPTH_LOG2;
    localparam int OW    = $clog2(LATENCY) + 1;
    localparam int PW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(LATENCY - 1);
    localparam logic [OW-1:0] LAT_CNT  = OW'(LATENCY);

    logic [DATA_WIDTH-1:0] mem [0:WORDS-1];

    logic [DEPTH_LOG2-1:0] idx_s;
    logic                  accept_s;
    logic                  retire_s;
    logic                  is_write_s;
    logic                  oor_s;
    logic                  addr_unused_s;
    logic [DATA_WIDTH-1:0] rd_word_s;

    logic [LATENCY-1:0]    dl_valid_r;
    logic [LATENCY-1:0]    dl_err_r;
    logic [DATA_WIDTH-1:0] dl_rdata_r [LATENCY];

    logic [DATA_WIDTH-1:0] fifo_rdata_r [LATENCY];
    logic [LATENCY-1:0]    fifo_err_r;
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [OW-1:0]         fifo_cnt_r;
    logic [OW-1:0]         outstanding_r;

    logic                  tail_valid_s;
    logic                  tail_err_s;
    logic [DATA_WIDTH-1:0] tail_rdata_s;
    logic                  fifo_empty_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  resp_err_s;

    assign idx_s         = req_addr[DEPTH_LOG2+BL-1:BL];
    assign addr_unused_s = ^req_addr;
    assign is_write_s    = |req_wen;
    assign accept_s      = req_valid && req_ready;
    assign retire_s      = resp_valid && resp_ready;
    assign req_ready     = (outstanding_r < LAT_CNT) || retire_s;

`ifdef RAM_RANGE_CHECK_EN
    assign oor_s    = (req_addr >> (DEPTH_LOG2 + BL)) != '0;
    assign resp_err = resp_err_s;

    // Report out-of-range accesses as they are accepted
    always_ff @(posedge clk) begin
        if (accept_s && oor_s) begin
            $display("sim_ram_pipe warning: out-of-range address 0x%h", req_addr);
        end
    end
`else
    logic err_unused_s;
    assign oor_s        = 1'b0;
    assign resp_err     = 1'b0;
    assign err_unused_s = resp_err_s;
`endif

    // Commit enabled byte lanes at the accept edge; memory is never reset
    always_ff @(posedge clk) begin
        if (accept_s && is_write_s && !oor_s) begin
            for (int i = 0; i < BYTES; i++) begin
                if (req_wen[i]) begin
                    mem[idx_s][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read word captured into the delay line; writes and flagged requests return zero
    always_comb begin
        rd_word_s = '0;
        if (accept_s && !is_write_s && !oor_s) begin
            rd_word_s = mem[idx_s];
        end else begin
            rd_word_s = '0;
        end
    end

    // LATENCY-stage delay line of {valid, rdata, err}
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_valid_r <= '0;
            dl_err_r   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dl_rdata_r[i] <= '0;
            end
        end else begin
            dl_valid_r[0] <= accept_s;
            dl_err_r[0]   <= accept_s && oor_s;
            dl_rdata_r[0] <= rd_word_s;
            for (int i = 1; i < LATENCY; i++) begin
                dl_valid_r[i] <= dl_valid_r[i-1];
                dl_err_r[i]   <= dl_err_r[i-1];
                dl_rdata_r[i] <= dl_rdata_r[i-1];
            end
        end
    end

    assign tail_valid_s = dl_valid_r[LATENCY-1];
    assign tail_err_s   = dl_err_r[LATENCY-1];
    assign tail_rdata_s = dl_rdata_r[LATENCY-1];
    assign fifo_empty_s = (fifo_cnt_r == '0);
    // An empty FIFO lets the tail bypass straight to the consumer when it is ready
    assign push_s       = tail_valid_s && !(fifo_empty_s && resp_ready);
    assign pop_s        = !fifo_empty_s && resp_ready;

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? '0 : wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? '0 : rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + OW'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - OW'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_rdata_r[wr_ptr_r] <= tail_rdata_s;
            fifo_err_r[wr_ptr_r]   <= tail_err_s;
        end
    end

    // Accepted-but-not-retired request count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_r <= '0;
        end else begin
            case ({accept_s, retire_s})
                2'b10:   outstanding_r <= outstanding_r + OW'(1);
                2'b01:   outstanding_r <= outstanding_r - OW'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Response mux: FIFO head when occupied, otherwise the delay-line tail
    always_comb begin
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err_s = 1'b0;
        if (fifo_empty_s) begin
            resp_valid = tail_valid_s;
            resp_rdata = tail_rdata_s;
            resp_err_s = tail_err_s;
        end else begin
            resp_valid = 1'b1;
            resp_rdata = fifo_rdata_r[rd_ptr_r];
            resp_err_s = fifo_err_r[rd_ptr_r];
        end
    end

endmodule
